// File: rtl/kernel_pr_ctrl_pkg.sv
// Shared control definitions for the PageRank kernel start scheduler.
package kernel_pr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        THROTTLE = 2'd2
    } sched_state_e;

    localparam logic START_TOKEN          = 1'b1;
    localparam int   DEFAULT_MAX_INFLIGHT = 8;

endpackage

// File: rtl/kernel_pr_start_sched_if.sv
// Control handshake and start-FIFO write bundle between kernel control and the scheduler.
interface kernel_pr_start_sched_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 4
);
    logic                 ap_start;
    logic                 ap_ready;
    logic                 ap_done;
    logic                 ap_continue;
    logic                 ap_idle;
    logic [NUM_CH-1:0]    start_full_n;
    logic [NUM_CH-1:0]    start_write;
    logic [NUM_CH-1:0]    start_din;
    logic                 proc_done;
    logic [CNT_WIDTH-1:0] inflight;
    logic                 err;

    modport master (
        output ap_start, ap_continue, start_full_n, proc_done,
        input  ap_ready, ap_done, ap_idle, start_write, start_din, inflight, err
    );

    modport slave (
        input  ap_start, ap_continue, start_full_n, proc_done,
        output ap_ready, ap_done, ap_idle, start_write, start_din, inflight, err
    );
endinterface

// File: rtl/kernel_pr_credit_cnt.sv
// Saturating up/down counter; simultaneous inc and dec leave the count unchanged.
module kernel_pr_credit_cnt #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt
);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + WIDTH'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end
endmodule

// File: rtl/kernel_pr_start_sched.sv
// Start scheduler: one start token per iteration on every start FIFO, with in-flight credit throttling.
module kernel_pr_start_sched
    import kernel_pr_ctrl_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_WIDTH    = 4,
    parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    kernel_pr_start_sched_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);
    localparam logic [CNT_WIDTH-1:0] MAX_M1  = CNT_WIDTH'(MAX_INFLIGHT - 1);

    sched_state_e         state;
    logic [NUM_CH-1:0]    issued;
    logic [NUM_CH-1:0]    start_write;
    logic                 ap_ready;
    logic                 ap_done;
    logic                 ack;
    logic                 spurious;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] inflight;
    logic [CNT_WIDTH-1:0] done_pend;

    always_comb begin
        start_write = '0;
        if (state == ISSUE) start_write = ~issued & bus.start_full_n;
    end

    assign ap_ready = (state == ISSUE) && (&(issued | start_write));
    assign ap_done  = (done_pend != '0);
    assign ack      = bus.ap_continue & ap_done;
    // A completion with every in-flight iteration already done cannot be real.
    assign spurious = bus.proc_done && (done_pend == inflight);

    kernel_pr_credit_cnt #(.WIDTH(CNT_WIDTH), .MAX(MAX_INFLIGHT)) u_inflight (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (ap_ready),
        .dec     (ack),
        .cnt     (inflight)
    );

    kernel_pr_credit_cnt #(.WIDTH(CNT_WIDTH), .MAX(MAX_INFLIGHT)) u_done_pend (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (bus.proc_done & ~spurious),
        .dec     (ack),
        .cnt     (done_pend)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            issued <= '0;
            err_q  <= 1'b0;
        end else begin
            if (spurious) err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.ap_start) state <= (inflight < MAX_CNT) ? ISSUE : THROTTLE;
                end
                ISSUE: begin
                    if (ap_ready) begin
                        issued <= '0;
                        if (bus.ap_start && inflight < MAX_M1) state <= ISSUE;
                        else if (bus.ap_start)                 state <= THROTTLE;
                        else                                   state <= IDLE;
                    end else begin
                        issued <= issued | start_write;
                    end
                end
                THROTTLE: begin
                    if (inflight < MAX_CNT) state <= ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_write = start_write;
    assign bus.start_din   = {NUM_CH{START_TOKEN}};
    assign bus.ap_ready    = ap_ready;
    assign bus.ap_done     = ap_done;
    assign bus.ap_idle     = (state == IDLE) && (inflight == '0) && !bus.ap_start;
    assign bus.inflight    = inflight;
    assign bus.err         = err_q;
endmodule
